reg_bank: RTL and testbench
===========================

# reg_bank

Parametrised register bank for the 6502 core. It replaces the fixed set of discrete PC/SP/ADD/X/Y/STAT registers and the 8:1 ALU operand muxes with one block. The block provides:
- N general registers with a single write port and a PC auto-increment.
- Two registered read ports, each with an immediate source and optional write bypass.
- A hardware stack pointer with push/pop and sticky overflow/underflow flags.
- A status register with per-bit masked update.

It sits between the decoder/ALU and the register state, and feeds the ALU `a`/`b` operands.

## Interface
Parameters:
- `WIDTH`, 8, data width of every register, immediate and port.
- `NUM_REGS`, 4, general registers. Index 0 is PC, 1 is ADD, 2 is X, 3 is Y; higher indices are spare.
- `BYPASS`, 1, when 1 a same-cycle write is forwarded to a read port that selects the written register.
- `SP_RESET`, 8'hFF, stack pointer reset value.
- `STAT_RESET`, 8'h20, status reset value.
- `SEL_W` is a localparam equal to `$clog2(NUM_REGS+1)`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  general register write enable.
- `wsel`  in  SEL_W  write index.
- `wdata`  in  WIDTH  write data.
- `pc_inc`  in  1  increment register 0 by 1.
- `imm`  in  WIDTH  immediate operand, selected by index `NUM_REGS`.
- `sel_a`, `sel_b`  in  SEL_W  read-port selects.
- `out_a`, `out_b`  out  WIDTH  registered read data.
- `sp_push`, `sp_pop`  in  1  stack pointer decrement / increment.
- `sp_out`  out  WIDTH  current stack pointer.
- `stack_ovf`, `stack_unf`  out  1  sticky wrap flags.
- `stat_mask`  in  WIDTH  per-bit status write enable.
- `stat_din`  in  WIDTH  status write data.
- `stat_out`  out  WIDTH  current status.

## Operation
- **Reset** (sampled on `clk` while `reset`=1) sets:
  - all general registers to 0;
  - `out_a` and `out_b` to 0;
  - `sp_out` to `SP_RESET`;
  - `stat_out` to `STAT_RESET`;
  - `stack_ovf` and `stack_unf` to 0.
  
  Reset overrides every other input.
- **Write:** when `we`=1 and `wsel < NUM_REGS`, register[`wsel`] takes `wdata`. When `wsel >= NUM_REGS` the write is ignored.
- **PC increment:** when `pc_inc`=1, reg0 takes reg0+1 modulo 2^WIDTH, so FF wraps to 00. If `we`=1 and `wsel`=0 in the same cycle, the write wins and the increment is dropped.
- **Read ports (each independently):**
  - `sel < NUM_REGS` returns register[`sel`];
  - `sel == NUM_REGS` returns `imm`;
  - `sel > NUM_REGS` returns 0.
  
  With `BYPASS`=1, a same-cycle write to the selected register returns `wdata`, and a same-cycle `pc_inc` on reg0 returns reg0+1. With `BYPASS`=0 the port returns the pre-edge value.
- **Stack pointer:**
  - push only: SP−1;
  - pop only: SP+1;
  - push and pop together, or neither: no change.
  
  A push at SP=00 wraps to FF and sets `stack_ovf`. A pop at SP=FF wraps to 00 and sets `stack_unf`. Both flags stay set until reset.
- **Status:** each bit i updates with `stat_din[i]` only where `stat_mask[i]`=1; all other bits hold.

## Timing
- Read latency is 1 cycle: `sel_a`, `sel_b` and `imm` sampled at edge k appear on `out_a`/`out_b` after edge k.
- Write-to-read without bypass takes 2 edges: the write lands at edge k and a read issued at edge k+1 returns it.
- `sp_out`, `stat_out` and the flags are register outputs. They update at the edge where the command is sampled, with no combinational path from inputs.
- There is no handshake; every command is accepted every cycle.

## Structure
- The shared package `PKG/pkg.v` holds:
  - `REG_WIDTH`;
  - register index macros `REG_PC`=0, `REG_ADD`=1, `REG_X`=2, `REG_Y`=3;
  - default `SP_RESET` and `STAT_RESET` values.
- Sub-module `reg_read_port` is instantiated twice. It contains the select decode, bypass logic and output register, parametrised by `WIDTH`, `NUM_REGS` and `BYPASS`.
- The register array, PC increment, SP and status logic stay in `reg_bank`.

## Test plan
- **Reset, write and read:** reset, then write X=8'h3C and Y=8'hA5. With `sel_a`=2 and `sel_b`=3, expect `out_a`=3C and `out_b`=A5 one cycle later. After reset, also expect `sp_out`=FF and `stat_out`=20.
- **Immediate and out-of-range selects:** `sel_a`=NUM_REGS with `imm`=8'h7E gives `out_a`=7E; `sel_b`=NUM_REGS+1 gives `out_b`=00. A write with `wsel`=NUM_REGS leaves every register unchanged.
- **PC wrap and priority:**
  - PC=FF with `pc_inc` gives PC=00;
  - `pc_inc` with a write to reg0 of 8'h10 gives PC=10;
  - with `BYPASS`=1 and `sel_a`=0 in the same cycle, `out_a`=10.
- **Bypass comparison:** write ADD=8'h55 while `sel_a`=1, with ADD previously 0. Expect `out_a`=55 for `BYPASS`=1 and 00 for `BYPASS`=0.
- **Stack:**
  - 255 pushes from FF give SP=00 with no flag set; the 256th push gives SP=FF and `stack_ovf`=1;
  - push and pop together leave SP unchanged;
  - a pop at FF gives SP=00 and `stack_unf`=1;
  - both flags hold until reset.
- **Status mask and mid-operation reset:**
  - status=20 with `stat_mask`=8'h81 and `stat_din`=8'hFF gives A1;
  - asserting `reset` in the same cycle as writes, push and status update gives all reset values.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared widths, register indices and reset defaults for the 6502 register bank.
package reg_bank_pkg;

    localparam int unsigned REG_WIDTH = 8;

    // Architectural register indices
    localparam int unsigned REG_PC  = 0;
    localparam int unsigned REG_ADD = 1;
    localparam int unsigned REG_X   = 2;
    localparam int unsigned REG_Y   = 3;

    // Default reset values for the stack pointer and status register
    localparam int unsigned DEF_SP_RESET   = 32'h0000_00FF;
    localparam int unsigned DEF_STAT_RESET = 32'h0000_0020;

endpackage

// File: rtl/reg_read_port.sv
// One registered read port: select decode (register / immediate / zero),
// optional same-cycle write and PC-increment forwarding, output register.
module reg_read_port
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH    = REG_WIDTH,
    parameter int unsigned NUM_REGS = 4,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned SEL_W   = $clog2(NUM_REGS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SEL_W-1:0]              sel,
    input  logic [WIDTH-1:0]              imm,
    input  logic [NUM_REGS-1:0][WIDTH-1:0] regs,
    input  logic                          we,
    input  logic [SEL_W-1:0]              wsel,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pc_inc,
    output logic [WIDTH-1:0]              data
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [IDX_W-1:0] sel_idx;
    logic [WIDTH-1:0] data_c;

    assign sel_idx = IDX_W'(sel);

    // Decode the select; a pending write beats a pending PC increment when forwarding
    always_comb begin
        data_c = '0;
        if (sel < SEL_W'(NUM_REGS)) begin
            data_c = regs[sel_idx];
            if (BYPASS) begin
                if (we && (wsel == sel)) begin
                    data_c = wdata;
                end else if (pc_inc && (sel == SEL_W'(REG_PC))) begin
                    data_c = regs[REG_PC] + WIDTH'(1);
                end
            end
        end else if (sel == SEL_W'(NUM_REGS)) begin
            data_c = imm;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else begin
            data <= data_c;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Register bank: general registers with PC auto-increment, two read ports,
// hardware stack pointer with sticky wrap flags, and a bit-masked status register.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned      WIDTH      = REG_WIDTH,
    parameter int unsigned      NUM_REGS   = 4,
    parameter bit               BYPASS     = 1'b1,
    parameter logic [WIDTH-1:0] SP_RESET   = WIDTH'(DEF_SP_RESET),
    parameter logic [WIDTH-1:0] STAT_RESET = WIDTH'(DEF_STAT_RESET),
    localparam int unsigned     SEL_W      = $clog2(NUM_REGS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [SEL_W-1:0] wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pc_inc,
    input  logic [WIDTH-1:0] imm,
    input  logic [SEL_W-1:0] sel_a,
    input  logic [SEL_W-1:0] sel_b,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    input  logic             sp_push,
    input  logic             sp_pop,
    output logic [WIDTH-1:0] sp_out,
    output logic             stack_ovf,
    output logic             stack_unf,
    input  logic [WIDTH-1:0] stat_mask,
    input  logic [WIDTH-1:0] stat_din,
    output logic [WIDTH-1:0] stat_out
);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs_q;

    // General registers; out-of-range write indices match no entry and are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (we && (wsel == SEL_W'(i))) begin
                    regs_q[i] <= wdata;
                end else if ((i == REG_PC) && pc_inc) begin
                    regs_q[i] <= regs_q[i] + WIDTH'(1);
                end
            end
        end
    end

    // Stack pointer: push decrements, pop increments, both or neither hold
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_out    <= SP_RESET;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (sp_push && !sp_pop) begin
            sp_out <= sp_out - WIDTH'(1);
            if (sp_out == '0) begin
                stack_ovf <= 1'b1;
            end
        end else if (sp_pop && !sp_push) begin
            sp_out <= sp_out + WIDTH'(1);
            if (sp_out == '1) begin
                stack_unf <= 1'b1;
            end
        end
    end

    // Status register: only masked bits take new data
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_out <= STAT_RESET;
        end else begin
            stat_out <= (stat_out & ~stat_mask) | (stat_din & stat_mask);
        end
    end

    reg_read_port #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS)
    ) u_port_a (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel_a),
        .imm    (imm),
        .regs   (regs_q),
        .we     (we),
        .wsel   (wsel),
        .wdata  (wdata),
        .pc_inc (pc_inc),
        .data   (out_a)
    );

    reg_read_port #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS)
    ) u_port_b (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel_b),
        .imm    (imm),
        .regs   (regs_q),
        .we     (we),
        .wsel   (wsel),
        .wdata  (wdata),
        .pc_inc (pc_inc),
        .data   (out_b)
    );

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: a bypassing and a non-bypassing instance share stimulus;
// a behavioural model queues expected outputs per cycle and they are checked after the edge.
module tb_reg_bank;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 3;

    logic          clk = 1'b0;
    logic          reset, we, pc_inc, sp_push, sp_pop;
    logic [SW-1:0] wsel, sel_a, sel_b;
    logic [W-1:0]  wdata, imm, stat_mask, stat_din;

    logic [W-1:0]  out_a, out_b, sp_out, stat_out;
    logic          stack_ovf, stack_unf;
    logic [W-1:0]  nb_out_a, nb_out_b, nb_sp_out, nb_stat_out;
    logic          nb_stack_ovf, nb_stack_unf;

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(W), .NUM_REGS(N), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .we(we), .wsel(wsel), .wdata(wdata), .pc_inc(pc_inc),
        .imm(imm), .sel_a(sel_a), .sel_b(sel_b), .out_a(out_a), .out_b(out_b),
        .sp_push(sp_push), .sp_pop(sp_pop), .sp_out(sp_out),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf),
        .stat_mask(stat_mask), .stat_din(stat_din), .stat_out(stat_out)
    );

    reg_bank #(.WIDTH(W), .NUM_REGS(N), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .we(we), .wsel(wsel), .wdata(wdata), .pc_inc(pc_inc),
        .imm(imm), .sel_a(sel_a), .sel_b(sel_b), .out_a(nb_out_a), .out_b(nb_out_b),
        .sp_push(sp_push), .sp_pop(sp_pop), .sp_out(nb_sp_out),
        .stack_ovf(nb_stack_ovf), .stack_unf(nb_stack_unf),
        .stat_mask(stat_mask), .stat_din(stat_din), .stat_out(nb_stat_out)
    );

    typedef struct {
        string        tag;
        int           src;
        logic [W-1:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference state
    logic [W-1:0] m_regs [N];
    logic [W-1:0] m_sp, m_stat;
    logic         m_ovf, m_unf;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] observed(input int src);
        case (src)
            0:  return out_a;
            1:  return out_b;
            2:  return nb_out_a;
            3:  return nb_out_b;
            4:  return sp_out;
            5:  return stat_out;
            6:  return W'(stack_ovf);
            7:  return W'(stack_unf);
            8:  return nb_sp_out;
            9:  return nb_stat_out;
            10: return W'(nb_stack_ovf);
            default: return W'(nb_stack_unf);
        endcase
    endfunction

    function automatic logic [W-1:0] model_read(input logic [SW-1:0] s, input bit byp);
        if (int'(s) > int'(N)) return '0;
        if (int'(s) == int'(N)) return imm;
        if (byp && we && wsel == s) return wdata;
        if (byp && pc_inc && s == '0) return m_regs[0] + 8'd1;
        return m_regs[int'(s)];
    endfunction

    task automatic push_exp(input string tag, input int src, input logic [W-1:0] v);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    // Predict this edge, let it happen, then compare everything that was queued
    task automatic cycle();
        logic [W-1:0] ea, eb, na, nb;
        exp_t e;
        if (reset) begin
            for (int i = 0; i < int'(N); i++) m_regs[i] = '0;
            m_sp = 8'hFF; m_stat = 8'h20; m_ovf = 1'b0; m_unf = 1'b0;
            ea = '0; eb = '0; na = '0; nb = '0;
        end else begin
            ea = model_read(sel_a, 1'b1);
            eb = model_read(sel_b, 1'b1);
            na = model_read(sel_a, 1'b0);
            nb = model_read(sel_b, 1'b0);
            if (we && int'(wsel) < int'(N)) m_regs[int'(wsel)] = wdata;
            if (pc_inc && !(we && wsel == '0)) m_regs[0] = m_regs[0] + 8'd1;
            if (sp_push && !sp_pop) begin
                if (m_sp == 8'h00) m_ovf = 1'b1;
                m_sp = m_sp - 8'd1;
            end else if (sp_pop && !sp_push) begin
                if (m_sp == 8'hFF) m_unf = 1'b1;
                m_sp = m_sp + 8'd1;
            end
            for (int i = 0; i < int'(W); i++) if (stat_mask[i]) m_stat[i] = stat_din[i];
        end
        push_exp("out_a", 0, ea);       push_exp("out_b", 1, eb);
        push_exp("nb_out_a", 2, na);    push_exp("nb_out_b", 3, nb);
        push_exp("sp", 4, m_sp);        push_exp("stat", 5, m_stat);
        push_exp("ovf", 6, W'(m_ovf));  push_exp("unf", 7, W'(m_unf));
        push_exp("nb_sp", 8, m_sp);     push_exp("nb_stat", 9, m_stat);
        push_exp("nb_ovf", 10, W'(m_ovf)); push_exp("nb_unf", 11, W'(m_unf));
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observed(e.src), e.exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; we = 1'b0; wsel = '0; wdata = '0; pc_inc = 1'b0; imm = '0;
        sel_a = '0; sel_b = '0; sp_push = 1'b0; sp_pop = 1'b0;
        stat_mask = '0; stat_din = '0;
    endtask

    task automatic write_reg(input logic [SW-1:0] idx, input logic [W-1:0] v);
        idle(); we = 1'b1; wsel = idx; wdata = v; cycle();
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; cycle(); reset = 1'b0;
    endtask

    initial begin
        idle();
        do_reset();
        check_eq("rst_sp", sp_out, 8'hFF);
        check_eq("rst_stat", stat_out, 8'h20);
        check_eq("rst_out_a", out_a, 8'h00);

        // Write X and Y, then read both
        write_reg(3'd2, 8'h3C);
        write_reg(3'd3, 8'hA5);
        idle(); sel_a = 3'd2; sel_b = 3'd3; cycle();
        check_eq("read_x", out_a, 8'h3C);
        check_eq("read_y", out_b, 8'hA5);

        // Immediate and out-of-range selects
        idle(); sel_a = 3'd4; imm = 8'h7E; sel_b = 3'd5; cycle();
        check_eq("imm_a", out_a, 8'h7E);
        check_eq("oor_b", out_b, 8'h00);
        idle(); sel_a = 3'd7; sel_b = 3'd4; imm = 8'h99; cycle();
        check_eq("oor7_a", out_a, 8'h00);

        // Writes to spare/out-of-range indices are dropped
        write_reg(3'd4, 8'hEE);
        write_reg(3'd7, 8'hDD);
        idle(); sel_a = 3'd0; sel_b = 3'd1; cycle();
        idle(); sel_a = 3'd2; sel_b = 3'd3; cycle();
        check_eq("oor_wr_x", out_a, 8'h3C);
        check_eq("oor_wr_y", out_b, 8'hA5);

        // PC wrap and write-over-increment priority
        write_reg(3'd0, 8'hFF);
        idle(); pc_inc = 1'b1; sel_a = 3'd0; cycle();
        check_eq("pc_wrap_byp", out_a, 8'h00);
        idle(); sel_a = 3'd0; cycle();
        check_eq("pc_wrap", out_a, 8'h00);
        idle(); pc_inc = 1'b1; we = 1'b1; wsel = 3'd0; wdata = 8'h10; sel_a = 3'd0; cycle();
        check_eq("pc_prio_byp", out_a, 8'h10);
        check_eq("pc_prio_nb", nb_out_a, 8'h00);
        idle(); sel_a = 3'd0; cycle();
        check_eq("pc_prio", out_a, 8'h10);

        // Bypass versus pre-edge value (ADD still 0 since reset)
        idle(); we = 1'b1; wsel = 3'd1; wdata = 8'h55; sel_a = 3'd1; cycle();
        check_eq("byp_on", out_a, 8'h55);
        check_eq("byp_off", nb_out_a, 8'h00);
        idle(); sel_a = 3'd1; cycle();
        check_eq("byp_off_next", nb_out_a, 8'h55);

        // Stack overflow after a full lap of pushes
        do_reset();
        for (int i = 0; i < 255; i++) begin
            idle(); sp_push = 1'b1; cycle();
        end
        check_eq("sp_255", sp_out, 8'h00);
        check_eq("ovf_255", W'(stack_ovf), 8'h00);
        idle(); sp_push = 1'b1; cycle();
        check_eq("sp_256", sp_out, 8'hFF);
        check_eq("ovf_256", W'(stack_ovf), 8'h01);
        idle(); sp_push = 1'b1; sp_pop = 1'b1; cycle();
        check_eq("sp_both", sp_out, 8'hFF);
        idle(); sp_pop = 1'b1; cycle();
        check_eq("sp_unf", sp_out, 8'h00);
        check_eq("unf_set", W'(stack_unf), 8'h01);
        for (int i = 0; i < 4; i++) begin
            idle(); sp_pop = 1'b1; cycle();
            idle(); sp_push = 1'b1; cycle();
        end
        check_eq("ovf_hold", W'(stack_ovf), 8'h01);
        check_eq("unf_hold", W'(stack_unf), 8'h01);

        // Status mask
        do_reset();
        idle(); stat_mask = 8'h81; stat_din = 8'hFF; cycle();
        check_eq("stat_a1", stat_out, 8'hA1);
        idle(); stat_mask = 8'h21; stat_din = 8'h00; cycle();
        check_eq("stat_80", stat_out, 8'h80);

        // Reset overriding simultaneous commands
        idle(); reset = 1'b1; we = 1'b1; wsel = 3'd2; wdata = 8'h77; pc_inc = 1'b1;
        sp_push = 1'b1; stat_mask = 8'hFF; stat_din = 8'h0F; sel_a = 3'd4; imm = 8'h42; cycle();
        check_eq("mid_rst_sp", sp_out, 8'hFF);
        check_eq("mid_rst_stat", stat_out, 8'h20);
        check_eq("mid_rst_ovf", W'(stack_ovf), 8'h00);
        check_eq("mid_rst_out", out_a, 8'h00);
        idle(); sel_a = 3'd2; sel_b = 3'd0; cycle();
        check_eq("mid_rst_x", out_a, 8'h00);
        check_eq("mid_rst_pc", out_b, 8'h00);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            idle();
            reset     = ($urandom_range(0, 63) == 0);
            we        = $urandom_range(0, 1) == 1;
            wsel      = SW'($urandom_range(0, 7));
            wdata     = W'($urandom);
            pc_inc    = $urandom_range(0, 2) == 0;
            imm       = W'($urandom);
            sel_a     = SW'($urandom_range(0, 7));
            sel_b     = SW'($urandom_range(0, 7));
            sp_push   = $urandom_range(0, 1) == 1;
            sp_pop    = $urandom_range(0, 1) == 1;
            stat_mask = W'($urandom);
            stat_din  = W'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
